// File: rtl/bin2bcd_disp_pkg.sv
// Purpose : shared constants for the bin2bcd_disp block (FSM encodings, default sizes, BCD limit, blank reset mask).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package bin2bcd_disp_pkg;

    localparam int BIN_W_DEF  = 27;
    localparam int DIGITS_DEF = 8;

    // FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned bcd_max(input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam longint unsigned BCD_MAX = bcd_max(DIGITS_DEF);

    // Only the units digit is visible out of reset.
    localparam logic [DIGITS_DEF-1:0] BLANK_RST = {{(DIGITS_DEF-1){1'b1}}, 1'b0};

endpackage

// File: rtl/bin2bcd_disp_if.sv
// Purpose : request/result bundle between a requester and bin2bcd_disp.
// Latency : n/a (wires only).
// Backpressure: none on the bus; requester watches oBUSY, starts are dropped while busy.
//   iSTART/iBIN : request and value (master -> slave)
//   oBUSY/oDONE : status; oDIG/oOVF/oBLANK : registered result (slave -> master)
interface bin2bcd_disp_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) ();
    logic                  iSTART;
    logic [BIN_W-1:0]      iBIN;
    logic                  oBUSY;
    logic                  oDONE;
    logic [4*DIGITS-1:0]   oDIG;
    logic                  oOVF;
    logic [DIGITS-1:0]     oBLANK;

    modport master (
        output iSTART, iBIN,
        input  oBUSY, oDONE, oDIG, oOVF, oBLANK
    );

    modport slave (
        input  iSTART, iBIN,
        output oBUSY, oDONE, oDIG, oOVF, oBLANK
    );
endinterface

// File: rtl/bin2bcd_disp_add3.sv
// Purpose : single-nibble double-dabble corrector (adds 3 to values 5..15).
// Latency : combinational.
// Backpressure: none.
//   in_dat : scratch nibble; out_dat : corrected nibble (no carry out)
module bcd_add3 (
    input  logic [3:0] in_dat,
    output logic [3:0] out_dat
);
    always_comb begin
        out_dat = (in_dat >= 4'd5) ? (in_dat + 4'd3) : in_dat;
    end
endmodule

// File: rtl/bin2bcd_disp.sv
// Purpose : sequential binary-to-BCD converter with overflow clamp and leading-zero blank mask.
// Latency : oDONE BIN_W+1 cycles after the accepting edge; next start accepted BIN_W+2 cycles after.
// Backpressure: iSTART only sampled in IDLE; requests while busy are dropped, no queueing.
//   iCLK/iRST_N : clock, async active-low reset
//   bus (slave) : iSTART/iBIN request, oBUSY/oDONE status, oDIG/oOVF/oBLANK result
module bin2bcd_disp
    import bin2bcd_disp_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    bin2bcd_disp_if.slave    bus
);

    localparam int                  CNT_W      = $clog2(BIN_W + 1);
    localparam int                  SCR_W      = 4 * DIGITS;
    localparam logic [BIN_W-1:0]    MAX_VAL    = BIN_W'(bcd_max(DIGITS));
    localparam logic [SCR_W-1:0]    ALL_NINES  = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0]   BLANK_INIT = {{(DIGITS-1){1'b1}}, 1'b0};

    logic [1:0]         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [BIN_W-1:0]   shreg_q,   shreg_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic               ovf_lat_q, ovf_lat_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [SCR_W-1:0]   dig_q,     dig_d;
    logic               ovf_q,     ovf_d;
    logic [DIGITS-1:0]  blank_q,   blank_d;

    logic [SCR_W-1:0]   adj;
    logic [DIGITS-1:0]  blank_calc;
    logic               hi_zero;

    // Per-digit add-3 correction, applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_dat  (scratch_q[4*g +: 4]),
            .out_dat (adj[4*g +: 4])
        );
    end

    // Walk down from the top digit: a digit is blank while everything above it is zero too.
    always_comb begin
        blank_calc = '0;
        hi_zero    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (scratch_q[4*i +: 4] != 4'd0) begin
                hi_zero = 1'b0;
            end
            blank_calc[i] = hi_zero;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        ovf_lat_d = ovf_lat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dig_d     = dig_q;
        ovf_d     = ovf_q;
        blank_d   = blank_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.iSTART) begin
                    shreg_d   = bus.iBIN;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    ovf_lat_d = (bus.iBIN > MAX_VAL);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // {scratch, shreg} << 1 after correction
                scratch_d = {adj[SCR_W-2:0], shreg_q[BIN_W-1]};
                shreg_d   = shreg_q << 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(BIN_W)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                dig_d   = ovf_lat_q ? ALL_NINES : scratch_q;
                ovf_d   = ovf_lat_q;
                blank_d = ovf_lat_q ? '0 : blank_calc;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            ovf_lat_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dig_q     <= '0;
            ovf_q     <= 1'b0;
            blank_q   <= BLANK_INIT;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            ovf_lat_q <= ovf_lat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dig_q     <= dig_d;
            ovf_q     <= ovf_d;
            blank_q   <= blank_d;
        end
    end

    assign bus.oBUSY  = busy_q;
    assign bus.oDONE  = done_q;
    assign bus.oDIG   = dig_q;
    assign bus.oOVF   = ovf_q;
    assign bus.oBLANK = blank_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Purpose : directed self-checking bench for bin2bcd_disp.
// Latency : expects oDONE 28 edges after acceptance, 29-cycle restart spacing.
// Backpressure: drives iSTART only; checks that starts during a conversion are dropped.
module tb_bin2bcd_disp;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    bin2bcd_disp_if #(.BIN_W(27), .DIGITS(8)) bus ();

    bin2bcd_disp #(.BIN_W(27), .DIGITS(8)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full conversion; optionally pulses iSTART mid-conversion with a different value.
    task automatic convert(input string tag, input logic [26:0] val, input logic [31:0] exp_dig,
                           input logic [7:0] exp_blank, input logic exp_ovf, input bit glitch);
        int          done_at;
        logic [31:0] prev_dig;
        done_at  = 0;
        prev_dig = bus.oDIG;
        @(negedge clk);
        bus.iBIN   = val;
        bus.iSTART = 1'b1;
        @(posedge clk);
        #1;
        bus.iSTART = 1'b0;
        bus.iBIN   = ~val;
        chk({tag, "_busy"}, 64'(bus.oBUSY), 64'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (glitch && k == 5) begin
                bus.iSTART = 1'b1;
                bus.iBIN   = 27'd999;
            end
            if (glitch && k == 7) bus.iSTART = 1'b0;
            if (k == 14) chk({tag, "_hold"}, 64'(bus.oDIG), 64'(prev_dig));
            if (bus.oDONE) begin
                done_at = k;
                break;
            end
        end
        chk({tag, "_lat"},   64'(done_at),     64'd28);
        chk({tag, "_dig"},   64'(bus.oDIG),    64'(exp_dig));
        chk({tag, "_blank"}, 64'(bus.oBLANK),  64'(exp_blank));
        chk({tag, "_ovf"},   64'(bus.oOVF),    64'(exp_ovf));
        chk({tag, "_nbusy"}, 64'(bus.oBUSY),   64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(bus.oDONE),   64'd0);
        chk({tag, "_keep"},  64'(bus.oDIG),    64'(exp_dig));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dig"},   64'(bus.oDIG),   64'd0);
        chk({tag, "_blank"}, 64'(bus.oBLANK), 64'hFE);
        chk({tag, "_busy"},  64'(bus.oBUSY),  64'd0);
        chk({tag, "_done"},  64'(bus.oDONE),  64'd0);
        chk({tag, "_ovf"},   64'(bus.oOVF),   64'd0);
    endtask

    // Expected results for iSTART held high with iBIN = 1000 + 7*cycle.
    logic [31:0] hs_dig [4] = '{32'h00001000, 32'h00001203, 32'h00001406, 32'h00001609};
    int          hs_cyc [4] = '{28, 57, 86, 115};

    initial begin
        int n_done;
        int seen_done;
        rst_n      = 1'b1;
        bus.iSTART = 1'b0;
        bus.iBIN   = '0;
        #3 rst_n = 1'b0;
        #20;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst_rel");

        convert("c12345678", 27'd12345678,  32'h12345678, 8'h00, 1'b0, 1'b0);
        convert("c0",        27'd0,         32'h00000000, 8'hFE, 1'b0, 1'b0);
        convert("c905",      27'd905,       32'h00000905, 8'hF8, 1'b0, 1'b0);
        convert("c99999999", 27'd99999999,  32'h99999999, 8'h00, 1'b0, 1'b0);
        convert("c1e8",      27'd100000000, 32'h99999999, 8'h00, 1'b1, 1'b0);
        convert("cmax",      27'd134217727, 32'h99999999, 8'h00, 1'b1, 1'b0);
        convert("c42",       27'd42,        32'h00000042, 8'hFC, 1'b0, 1'b0);
        convert("c555g",     27'd555,       32'h00000555, 8'hF8, 1'b0, 1'b1);

        // Level-held start with a changing value: one result every 29 cycles.
        n_done = 0;
        for (int c = 0; c <= 115; c++) begin
            @(negedge clk);
            bus.iSTART = 1'b1;
            bus.iBIN   = 27'(1000 + 7 * c);
            @(posedge clk);
            #1;
            if (bus.oDONE) begin
                if (n_done < 4) begin
                    chk($sformatf("hs%0d_cyc", n_done), 64'(c), 64'(hs_cyc[n_done]));
                    chk($sformatf("hs%0d_dig", n_done), 64'(bus.oDIG), 64'(hs_dig[n_done]));
                end
                n_done++;
            end
        end
        @(negedge clk);
        bus.iSTART = 1'b0;
        chk("hs_count", 64'(n_done), 64'd4);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus.iBIN   = 27'd1234567;
        bus.iSTART = 1'b1;
        @(posedge clk);
        #1;
        bus.iSTART = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        seen_done = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.oDONE) seen_done = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.oDONE) seen_done = 1;
        end
        chk("mid_nodone", 64'(seen_done), 64'd0);
        chk_reset_vals("mid_after");
        convert("c7", 27'd7, 32'h00000007, 8'hFE, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
